card_deck: RTL
==============

Name: card_deck

Overview:
- Random card source for the blackjack game. It draws cards without replacement from a single 52-card deck.
- Sits directly upstream of blackjack_FSM. It is requested whenever the FSM deals a card to a player or to the dealer.
- Returns rank, suit and blackjack value through a request/valid handshake.
- Uses a free-running 16-bit LFSR and a 52-bit used-card bitmap. The deck is refilled by a shuffle pulse.

Parameters:
- RESET_SEED, 16'hACE1, LFSR value after reset, and the substitute used whenever a zero seed is loaded.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- draw_req  input  1  single-cycle request for one card; honoured only while ready=1.
- shuffle  input  1  single-cycle pulse that returns all 52 cards to the deck.
- seed_load  input  1  single-cycle pulse that loads seed into the LFSR.
- seed  input  16  LFSR seed value.
- ready  output  1  block is idle and can accept draw_req.
- card_valid  output  1  one-cycle pulse; the card outputs are new this cycle.
- card_rank  output  4  rank, 1 to 13 (1=Ace, 11=J, 12=Q, 13=K).
- card_suit  output  2  suit, 0 to 3.
- card_value  output  4  blackjack value: rank for ranks 1 to 10, and 10 for ranks 11 to 13.
- deck_empty  output  1  one-cycle pulse when a draw_req arrives with no cards left.
- cards_left  output  6  number of undrawn cards, 0 to 52.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, used bitmap=0, cards_left=52, lfsr=RESET_SEED.
  - card_valid=0, deck_empty=0, card_rank=0, card_suit=0, card_value=0.
  - ready=1 once reset is released. Asserting reset mid-search aborts the search; no card_valid is produced.
- LFSR:
  - Advances every clock in every state: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - seed_load overrides the advance: lfsr <= (seed==0) ? RESET_SEED : seed.
- Card index: idx = suit*13 + (rank-1), range 0 to 51.
- Reverse mapping is combinational: suit = idx/13 and rank = idx%13 + 1, implemented with compares and subtracts, not a divider.
- States: IDLE and PROBE. ready = (state==IDLE).
- IDLE, on draw_req with cards_left>0:
  - idx <= (lfsr[5:0] >= 52) ? lfsr[5:0]-52 : lfsr[5:0].
  - Go to PROBE.
- IDLE, on draw_req with cards_left==0:
  - deck_empty=1 on the next cycle, for one cycle only. Stay in IDLE; the bitmap is unchanged.
- PROBE, if used[idx]==0:
  - used[idx] <= 1 and cards_left <= cards_left-1.
  - Register card_rank, card_suit and card_value from idx.
  - card_valid=1 for one cycle, then return to IDLE.
- PROBE, if used[idx]==1:
  - idx <= (idx==51) ? 0 : idx+1, wrapping 51 to 0. Stay in PROBE.
- Latency: draw_req to card_valid is 2 cycles minimum and 53 cycles maximum. PROBE always terminates because cards_left>0 guarantees a free slot.
- Card outputs hold their last values until the next card_valid. card_valid and deck_empty are never high in the same cycle.
- shuffle, in any state:
  - used <= 0 and cards_left <= 52.
  - In PROBE, the search is aborted and the block returns to IDLE with no card_valid; the pending draw is dropped and the requester must re-request.
- shuffle and draw_req in the same cycle: shuffle wins and the draw_req is ignored.
- shuffle and seed_load in the same cycle: both take effect.
- draw_req while ready=0 is ignored; it is neither queued nor flagged.
- cards_left is a registered output and updates in the same cycle that card_valid is asserted.

Test Plan:
- Reset, then seed_load with seed=16'h0000:
  - ready=1, cards_left=52, card_valid=0.
  - The internal LFSR reads 16'hACE1; check by the reference-model sequence of the first drawn card.
- 52 back-to-back draws, each issued when ready=1:
  - Exactly 52 card_valid pulses; every (suit, rank) pair appears once.
  - cards_left steps 51 down to 0.
  - card_value=10 for every rank from 11 to 13, and equals rank otherwise.
- 53rd draw_req after the deck is exhausted:
  - deck_empty=1 for exactly 1 cycle, no card_valid, cards_left stays 0, ready stays 1.
- Collision and wrap, forced via seed_load:
  - Load a seed whose next candidate idx is 51 while 51 and 0 are already used.
  - Required: probe goes 51, then 0, then 1; card_valid appears 4 cycles after draw_req with rank=2, suit=0.
- shuffle pulsed during PROBE, with 50 cards drawn:
  - No card_valid; returns to IDLE the next cycle; cards_left=52.
  - The following 52 draws again give each card exactly once.
- Reset asserted while in PROBE:
  - All outputs return to their reset values immediately, without waiting for a clock.
  - A draw after reset release succeeds with cards_left=51.

Source files
------------

// File: rtl/card_deck.sv
// rtl/card_deck.sv - draw-without-replacement card source for the blackjack dealer
//
// Purpose: hands out cards from one 52-card deck in random order. A free-running
// 16-bit LFSR picks a candidate slot. If that slot is already used, the search steps
// linearly through the used-card bitmap until it finds a free card.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   draw_req    request one card (only honoured while ready=1)
//   shuffle     return all 52 cards to the deck (aborts a search in progress)
//   seed_load   load seed into the LFSR (zero seed -> RESET_SEED)
//   seed        LFSR seed value
//   ready       idle, can accept draw_req
//   card_valid  one-cycle pulse, card outputs updated this cycle
//   card_rank   1..13 (1=Ace, 11=J, 12=Q, 13=K)
//   card_suit   0..3
//   card_value  blackjack value, 10 for face cards
//   deck_empty  one-cycle pulse: draw_req arrived with no cards left
//   cards_left  undrawn cards, 0..52
module card_deck #(
    parameter logic [15:0] RESET_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        draw_req,
    input  logic        shuffle,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic        ready,
    output logic        card_valid,
    output logic [3:0]  card_rank,
    output logic [1:0]  card_suit,
    output logic [3:0]  card_value,
    output logic        deck_empty,
    output logic [5:0]  cards_left
);

    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [51:0] used_q, used_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  left_q, left_d;
    logic        valid_q, valid_d;
    logic        empty_q, empty_d;
    logic [3:0]  rank_q, rank_d;
    logic [1:0]  suit_q, suit_d;
    logic [3:0]  value_q, value_d;

    // Candidate slot: the LFSR low six bits folded into 0..51 with a single subtract.
    logic [5:0] cand;
    assign cand = (lfsr_q[5:0] >= 6'd52) ? (lfsr_q[5:0] - 6'd52) : lfsr_q[5:0];

    // idx -> (suit, rank) using compares and subtracts instead of a divider.
    logic [1:0] map_suit;
    logic [3:0] map_rem;
    logic [3:0] map_rank;
    logic [3:0] map_value;

    always_comb begin
        map_suit = 2'd0;
        map_rem  = idx_q[3:0];
        if (idx_q >= 6'd39) begin
            map_suit = 2'd3;
            map_rem  = 4'(idx_q - 6'd39);
        end else if (idx_q >= 6'd26) begin
            map_suit = 2'd2;
            map_rem  = 4'(idx_q - 6'd26);
        end else if (idx_q >= 6'd13) begin
            map_suit = 2'd1;
            map_rem  = 4'(idx_q - 6'd13);
        end
        map_rank  = map_rem + 4'd1;
        map_value = (map_rank > 4'd10) ? 4'd10 : map_rank;
    end

    always_comb begin
        lfsr_d  = seed_load ? ((seed == 16'h0000) ? RESET_SEED : seed)
                            : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        state_d = state_q;
        idx_d   = idx_q;
        used_d  = used_q;
        left_d  = left_q;
        valid_d = 1'b0;
        empty_d = 1'b0;
        rank_d  = rank_q;
        suit_d  = suit_q;
        value_d = value_q;

        case (state_q)
            IDLE: begin
                if (draw_req && !shuffle) begin
                    if (left_q != 6'd0) begin
                        idx_d   = cand;
                        state_d = PROBE;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            PROBE: begin
                if (!shuffle) begin
                    if (!used_q[idx_q]) begin
                        used_d[idx_q] = 1'b1;
                        left_d        = left_q - 6'd1;
                        valid_d       = 1'b1;
                        rank_d        = map_rank;
                        suit_d        = map_suit;
                        value_d       = map_value;
                        state_d       = IDLE;
                    end else begin
                        idx_d = (idx_q == 6'd51) ? 6'd0 : (idx_q + 6'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Shuffle overrides everything: a pending draw is dropped, not completed.
        if (shuffle) begin
            used_d  = '0;
            left_d  = 6'd52;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= RESET_SEED;
            used_q  <= '0;
            idx_q   <= 6'd0;
            left_q  <= 6'd52;
            valid_q <= 1'b0;
            empty_q <= 1'b0;
            rank_q  <= 4'd0;
            suit_q  <= 2'd0;
            value_q <= 4'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            used_q  <= used_d;
            idx_q   <= idx_d;
            left_q  <= left_d;
            valid_q <= valid_d;
            empty_q <= empty_d;
            rank_q  <= rank_d;
            suit_q  <= suit_d;
            value_q <= value_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign card_valid = valid_q;
    assign deck_empty = empty_q;
    assign card_rank  = rank_q;
    assign card_suit  = suit_q;
    assign card_value = value_q;
    assign cards_left = left_q;

endmodule
